// File: rtl/rgbled_seq_if.sv
// rgbled_seq_if: go/valid/last/ack frame handshake between the sequencer (master) and the WS281x driver (slave).
interface rgbled_seq_if;
  logic        go;
  logic [23:0] data;
  logic        valid;
  logic        last;
  logic        ack;
  logic        idle;
  modport master (output go, data, valid, last, input ack, idle);
  modport slave (input go, data, valid, last, output ack, idle);
endinterface

// File: rtl/rgbled_seq.sv
// rgbled_seq: streams one GRB word per LED to the WS281x driver after reset, writes, refresh and timer expiry.
// Define RGBLED_SEQ_DIM_EN to scale each channel by (bright_i+1)/256 as the word is loaded.
module rgbled_seq #(
  parameter int NumLeds       = 2,
  parameter int RefreshCycles = 25000,
  parameter int IdxW          = (NumLeds > 1) ? $clog2(NumLeds) : 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             led_we_i,
  input  logic [IdxW-1:0]  led_idx_i,
  input  logic [23:0]      led_rgb_i,
  input  logic             refresh_i,
  input  logic [7:0]       bright_i,
  output logic             busy_o,
  output logic [15:0]      frame_cnt_o,
  rgbled_seq_if.master     drv
);
  localparam logic [1:0] StIdle = 2'd0, StStream = 2'd1, StDone = 2'd2;
  localparam int TmrW = (RefreshCycles > 1) ? $clog2(RefreshCycles) : 1;
  logic [1:0]      state_q, state_d;
  logic [IdxW-1:0] idx_q, idx_d, rd_idx;
  logic [23:0]     data_q, data_d, rd_col, word;
  logic [23:0]     col_q [NumLeds];
  logic            pend_q, pend_d;
  logic [15:0]     cnt_q, cnt_d;
  logic [TmrW-1:0] tmr_q, tmr_d;
  logic            tmr_exp, wr_ok, stream, last_w, start, adv;
  assign wr_ok  = led_we_i && (32'(led_idx_i) < NumLeds);
  assign stream = state_q == StStream;
  assign last_w = idx_q == IdxW'(NumLeds - 1);
  assign start  = (state_q == StIdle) && pend_q && drv.idle;
  assign adv    = stream && drv.ack && !last_w;
  assign rd_idx = start ? '0 : idx_q + IdxW'(1);
  assign rd_col = col_q[rd_idx];
`ifdef RGBLED_SEQ_DIM_EN
  function automatic logic [7:0] dim(input logic [7:0] c, input logic [7:0] b);
    logic [15:0] p;
    p = {8'd0, c} * ({8'd0, b} + 16'd1);
    return p[15:8];
  endfunction
  assign word = {dim(rd_col[15:8], bright_i), dim(rd_col[23:16], bright_i), dim(rd_col[7:0], bright_i)};
`else
  logic unused_bright;
  assign unused_bright = ^bright_i;
  assign word = {rd_col[15:8], rd_col[23:16], rd_col[7:0]};
`endif
  if (RefreshCycles > 0) begin : g_tmr
    assign tmr_exp = tmr_q == TmrW'(RefreshCycles - 1);
    assign tmr_d   = tmr_exp ? '0 : tmr_q + TmrW'(1);
  end else begin : g_no_tmr
    assign tmr_exp = 1'b0;
    assign tmr_d   = tmr_q;
  end
  // A set request in the load cycle survives the clear, so that change gets its own frame.
  assign pend_d  = wr_ok || refresh_i || tmr_exp || (pend_q && !start);
  assign state_d = start ? StStream : (stream && drv.ack && last_w) ? StDone : (state_q == StDone) ? StIdle : state_q;
  assign idx_d   = start ? '0 : adv ? idx_q + IdxW'(1) : idx_q;
  assign data_d  = (start || adv) ? word : (stream && !drv.ack) ? data_q : '0;
  assign cnt_d   = cnt_q + 16'(state_q == StDone);
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= StIdle;
      idx_q   <= '0;
      data_q  <= '0;
      pend_q  <= 1'b1;
      cnt_q   <= '0;
      tmr_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      data_q  <= data_d;
      pend_q  <= pend_d;
      cnt_q   <= cnt_d;
      tmr_q   <= tmr_d;
    end
  end
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < NumLeds; i++) col_q[i] <= '0;
    end else if (wr_ok) begin
      col_q[led_idx_i] <= led_rgb_i;
    end
  end
  assign drv.go      = stream;
  assign drv.valid   = stream;
  assign drv.last    = stream && last_w;
  assign drv.data    = stream ? data_q : '0;
  assign busy_o      = state_q != StIdle;
  assign frame_cnt_o = cnt_q;
endmodule

// File: tb/tb_rgbled_seq.sv
// tb_rgbled_seq: directed scoreboard bench; unit 0 has two LEDs and no timer, unit 1 has three LEDs and a 100-cycle refresh.
module tb_rgbled_seq;
`ifdef RGBLED_SEQ_DIM_EN
  localparam logic [23:0] DimW0 = 24'h007F00, DimW1 = 24'h407F20;
`else
  localparam logic [23:0] DimW0 = 24'h00FF00, DimW1 = 24'h80FF40;
`endif
  logic clk = 1'b0, rst = 1'b1;
  always #5 clk = ~clk;
  int checks = 0, failures = 0;
  logic we0 = 1'b0, idx0 = 1'b0, refresh0 = 1'b0;
  logic [23:0] rgb0 = '0;
  logic [7:0] bright = 8'd255;
  logic busy0;
  logic [15:0] cnt0;
  rgbled_seq_if b0 ();
  rgbled_seq #(.NumLeds(2), .RefreshCycles(0)) u0 (
    .clk_i(clk), .rst_i(rst), .led_we_i(we0), .led_idx_i(idx0), .led_rgb_i(rgb0),
    .refresh_i(refresh0), .bright_i(bright), .busy_o(busy0), .frame_cnt_o(cnt0), .drv(b0.master));
  logic we1 = 1'b0;
  logic [1:0] idx1 = '0;
  logic [23:0] rgb1 = '0;
  logic busy1;
  logic [15:0] cnt1;
  rgbled_seq_if b1 ();
  rgbled_seq #(.NumLeds(3), .RefreshCycles(100)) u1 (
    .clk_i(clk), .rst_i(rst), .led_we_i(we1), .led_idx_i(idx1), .led_rgb_i(rgb1),
    .refresh_i(1'b0), .bright_i(bright), .busy_o(busy1), .frame_cnt_o(cnt1), .drv(b1.master));
  logic [24:0] exp_q [$];
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  // Driver model for unit 0: ack each word on its third valid cycle and score it against the queue.
  initial begin
    int wait_n;
    logic gap;
    logic [24:0] e;
    wait_n = 0;
    gap = 1'b0;
    b0.ack = 1'b0;
    forever begin
      @(negedge clk);
      if (gap) chk("gap_after_last", {b0.go, b0.valid, b0.last}, 0);
      gap = 1'b0;
      if (b0.valid && !b0.ack) begin
        wait_n++;
        if (wait_n == 3) begin
          wait_n = 0;
          b0.ack = 1'b1;
          if (exp_q.size() == 0) chk("unexpected_word", exp_q.size(), 1);
          else begin
            e = exp_q.pop_front();
            chk("word", {b0.last, b0.data}, e);
            chk("busy_in_frame", busy0, 1);
            gap = e[24];
          end
        end
      end else begin
        b0.ack = 1'b0;
        wait_n = 0;
      end
    end
  end
  task automatic write0(input logic i, input logic [23:0] c);
    we0 = 1'b1; idx0 = i; rgb0 = c;
    @(negedge clk);
    we0 = 1'b0;
  endtask
  task automatic pulse_refresh();
    refresh0 = 1'b1;
    @(negedge clk);
    refresh0 = 1'b0;
  endtask
  task automatic push_frame(input logic [23:0] w0, input logic [23:0] w1);
    exp_q.push_back({1'b0, w0});
    exp_q.push_back({1'b1, w1});
  endtask
  task automatic drain(input string tag);
    int n;
    n = 0;
    do begin @(negedge clk); n++; end while ((exp_q.size() != 0 || busy0) && n < 500);
    chk({tag, "_drain"}, {30'd0, exp_q.size() != 0, busy0}, 0);
  endtask
  task automatic wait_go(input string tag);
    int n;
    n = 0;
    while (!b0.go && n < 20) begin @(negedge clk); n++; end
    chk({tag, "_go"}, b0.go, 1);
  endtask
  task automatic next_frame1(output int n);
    logic prev;
    n = 0;
    do begin prev = b1.go; @(negedge clk); n++; end while (!(b1.go && !prev) && n < 300);
  endtask
  initial begin
    int n, seen;
    logic [15:0] c1;
    b0.idle = 1'b1;
    b1.ack = 1'b1;
    b1.idle = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_ctl0", {b0.go, b0.valid, b0.last, busy0}, 0);
    chk("rst_data0", b0.data, 0);
    chk("rst_cnt0", cnt0, 0);
    chk("rst_ctl1", {b1.go, b1.valid, b1.last, busy1}, 0);
    push_frame(24'h000000, 24'h000000);
    rst = 1'b0;
    drain("t1");
    chk("t1_cnt", cnt0, 1);
    write0(1'b0, 24'h112233);
    write0(1'b1, 24'hAABBCC);
    push_frame(24'h221133, 24'hBBAACC);
    push_frame(24'h221133, 24'hBBAACC);
    drain("t2");
    chk("t2_cnt", cnt0, 3);
    b0.idle = 1'b0;
    pulse_refresh();
    for (int i = 0; i < 50; i++) begin @(negedge clk); chk("t3_hold", b0.go, 0); end
    push_frame(24'h221133, 24'hBBAACC);
    b0.idle = 1'b1;
    @(negedge clk);
    chk("t3_start", b0.go, 1);
    drain("t3");
    chk("t3_cnt", cnt0, 4);
    push_frame(24'h221133, 24'hBBAACC);
    push_frame(24'h00FF00, 24'hBBAACC);
    pulse_refresh();
    wait_go("t4");
    write0(1'b0, 24'hFF0000);
    drain("t4");
    chk("t4_cnt", cnt0, 6);
    next_frame1(n);
    next_frame1(n);
    chk("t5_period_a", n, 100);
    next_frame1(n);
    chk("t5_period_b", n, 100);
    repeat (5) @(negedge clk);
    c1 = cnt1;
    we1 = 1'b1; idx1 = 2'd3; rgb1 = 24'hFFFFFF;
    @(negedge clk);
    we1 = 1'b0;
    seen = 0;
    for (int i = 0; i < 20; i++) begin @(negedge clk); seen += int'(b1.go); end
    chk("t5_oor_go", seen, 0);
    chk("t5_oor_cnt", cnt1, c1);
    next_frame1(n);
    chk("t5_period_oor", n, 74);
    for (int i = 0; i < 3; i++) begin
      chk("t5_word", {b1.last, b1.data}, {7'd0, i == 2, 24'd0});
      @(negedge clk);
    end
    bright = 8'd127;
    write0(1'b1, 24'hFF8040);
    push_frame(DimW0, DimW1);
    drain("t6");
    chk("t6_cnt", cnt0, 7);
    pulse_refresh();
    wait_go("t6r");
    rst = 1'b1;
    #1;
    chk("t6_rst_ctl", {b0.go, b0.valid, b0.last, busy0}, 0);
    chk("t6_rst_data", b0.data, 0);
    chk("t6_rst_cnt", cnt0, 0);
    exp_q.delete();
    push_frame(24'h000000, 24'h000000);
    @(negedge clk);
    rst = 1'b0;
    drain("t6_fresh");
    chk("t6_fresh_cnt", cnt0, 1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
